interrupt_ctrl: RTL

Interrupt front end feeding the CP0/register-file stage. It samples four external interrupt lines, latches them as pending events, and applies the CP0 interrupt-enable and mask state plus an in-service priority scheme. At a safe writeback point it issues a one-cycle take strobe that makes CP0 save the return PC and makes the pipeline redirect to a per-source vector. ERET retires the in-service level so lower-priority sources can be taken again.

---
 rtl/interrupt_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/interrupt_ctrl.sv
// rtl/interrupt_ctrl.sv - interrupt front end: edge capture, masking, nested priority, take strobe
//
// Ports:
//   in_clk, in_RST      clock (rising edge), asynchronous active-low reset
//   in_irq[3:0]         raw asynchronous interrupt lines; a rising edge is one event
//   in_IE, in_INM[3:0]  CP0 global enable and per-source mask (1 = blocked)
//   in_wb_valid         writeback holds a retiring instruction (safe take point)
//   in_wb_pc[31:0]      PC of the retiring instruction (word address)
//   in_eret             ERET retiring, one-cycle pulse
//   out_BK, out_NIE     one-cycle take strobe: redirect to out_vec, save EPC, clear IE
//   out_WB_PC[31:0]     return PC captured at the take
//   out_vec, out_id     handler address and source id of the last take
//   out_pending, out_isr pending-event and in-service bits
module interrupt_ctrl #(
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'd16
) (
   input  logic        in_clk,
   input  logic        in_RST,
   input  logic [3:0]  in_irq,
   input  logic        in_IE,
   input  logic [3:0]  in_INM,
   input  logic        in_wb_valid,
   input  logic [31:0] in_wb_pc,
   input  logic        in_eret,
   output logic        out_BK,
   output logic        out_NIE,
   output logic [31:0] out_WB_PC,
   output logic [31:0] out_vec,
   output logic [1:0]  out_id,
   output logic [3:0]  out_pending,
   output logic [3:0]  out_isr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      TAKE = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [3:0]  s1, s2, s3;
   logic [3:0]  pending, isr;
   logic [1:0]  id, id_nx;
   logic [3:0]  rise;
   logic [2:0]  level;
   logic [3:0]  eligible;
   logic [1:0]  cand;
   logic        take;
   logic [3:0]  take_mask;
   logic [3:0]  isr_low;
   logic [3:0]  eret_mask;

   // s1/s2 form the metastability synchronizer; s3 is only the history for edge detection.
   assign rise = s2 & ~s3;

   // Current in-service level: lowest set isr index, 4 when nothing is in service.
   always_comb begin
      level = 3'd4;
      for (int i = 3; i >= 0; i--) begin
         if (isr[i]) level = 3'(i);
      end
   end

   // Only strictly higher-priority sources than the in-service one may be taken.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < 4; i++) begin
         eligible[i] = pending[i] & ~in_INM[i] & (3'(i) < level);
      end
   end

   always_comb begin
      cand = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (eligible[i]) cand = 2'(i);
      end
   end

   always_comb begin
      state_nx = state;
      id_nx    = id;
      take     = 1'b0;
      case (state)
         IDLE: begin
            if (in_IE && (eligible != 4'b0)) begin
               id_nx    = cand;
               state_nx = ARM;
            end
         end
         ARM: begin
            if (!in_IE || (eligible == 4'b0)) begin
               state_nx = IDLE;
            end else if (in_wb_valid) begin
               state_nx = TAKE;
               id_nx    = cand;
               take     = 1'b1;
            end else if (!eligible[id] || (cand < id)) begin
               id_nx = cand;
            end
         end
         TAKE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign take_mask = take ? (4'b0001 << cand) : 4'b0000;
   assign isr_low   = isr & (~isr + 4'd1);
   assign eret_mask = in_eret ? isr_low : 4'b0000;

   always_ff @(posedge in_clk or negedge in_RST) begin
      if (!in_RST) begin
         state     <= IDLE;
         s1        <= '0;
         s2        <= '0;
         s3        <= '0;
         pending   <= '0;
         isr       <= '0;
         id        <= '0;
         out_WB_PC <= '0;
         out_vec   <= '0;
         out_id    <= '0;
      end else begin
         state <= state_nx;
         s1    <= in_irq;
         s2    <= s1;
         s3    <= s2;
         id    <= id_nx;
         // Set terms are OR-ed last so a coincident new event / take wins over the clear.
         pending <= (pending & ~take_mask) | rise;
         isr     <= (isr & ~eret_mask) | take_mask;
         if (take) begin
            out_WB_PC <= in_wb_pc + 32'd1;
            out_id    <= cand;
            out_vec   <= VEC_BASE + 32'(cand) * VEC_STRIDE;
         end
      end
   end

   assign out_BK      = (state == TAKE);
   assign out_NIE     = (state == TAKE);
   assign out_pending = pending;
   assign out_isr     = isr;

endmodule
